// File: rtl/ann_mac_sequencer.sv
// Control and sequencing for the ANN fully-connected layer MAC datapath.
// Avalon-MM register slave plus a per-neuron clear/MAC/drain/activate/write FSM.
module ann_mac_sequencer #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DIM_W   = 8,
   parameter int unsigned MAC_LAT = 2
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [1:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic [ADDR_W-1:0] w_addr,
   output logic [DIM_W-1:0]  x_addr,
   output logic              mac_clr,
   output logic              mac_en,
   output logic              act_strobe,
   output logic [DIM_W-1:0]  y_addr,
   output logic              y_we,
   output logic              irq,
   output logic [7:0]        leds
);

   localparam int unsigned CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_MAC, S_DRAIN, S_ACT, S_WRITE, S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic              irq_en_q, irq_en_d;
   logic              done_q, done_d;
   logic [DIM_W-1:0]  n_in_q, n_in_d;
   logic [DIM_W-1:0]  n_out_q, n_out_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DIM_W-1:0]  i_q, i_d;
   logic [DIM_W-1:0]  j_q, j_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0]       avs_readdata_q, avs_readdata_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [DIM_W-1:0]  x_addr_q, x_addr_d;
   logic [DIM_W-1:0]  y_addr_q, y_addr_d;
   logic              mac_clr_q, mac_clr_d;
   logic              mac_en_q, mac_en_d;
   logic              act_strobe_q, act_strobe_d;
   logic              y_we_q, y_we_d;
   logic              irq_q, irq_d;
   logic [7:0]        leds_q, leds_d;

   logic wr_ctrl, wr_status, wr_dims, wr_base;
   logic start_req, abort_req, busy_q, busy_d;
   logic unused_wdata;

   assign unused_wdata = ^avs_writedata;

   // Register writes, FSM next state and registered output values.
   always_comb begin
      state_d        = state_q;
      irq_en_d       = irq_en_q;
      done_d         = done_q;
      n_in_d         = n_in_q;
      n_out_d        = n_out_q;
      base_d         = base_q;
      ptr_d          = ptr_q;
      i_d            = i_q;
      j_d            = j_q;
      cnt_d          = cnt_q;
      avs_readdata_d = 32'd0;
      w_addr_d       = w_addr_q;
      x_addr_d       = x_addr_q;
      y_addr_d       = y_addr_q;

      wr_ctrl   = avs_write && (avs_address == 2'd0);
      wr_status = avs_write && (avs_address == 2'd1);
      wr_dims   = avs_write && (avs_address == 2'd2);
      wr_base   = avs_write && (avs_address == 2'd3);
      abort_req = wr_ctrl && avs_writedata[2];
      start_req = wr_ctrl && avs_writedata[0] && !avs_writedata[2];
      busy_q    = (state_q != S_IDLE) && (state_q != S_DONE);

      if (wr_ctrl) irq_en_d = avs_writedata[1];
      if (wr_status && avs_writedata[1]) done_d = 1'b0;
      if (wr_dims && !busy_q) begin
         n_in_d  = avs_writedata[DIM_W-1:0];
         n_out_d = avs_writedata[DIM_W+7:8];
      end
      if (wr_base && !busy_q) base_d = avs_writedata[ADDR_W-1:0];

      unique case (state_q)
         S_IDLE: begin
            if (start_req) begin
               done_d = 1'b0;
               j_d    = '0;
               ptr_d  = base_q;
               // Empty layer completes at once without touching the datapath.
               if ((n_in_q == '0) || (n_out_q == '0)) done_d = 1'b1;
               else                                   state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            i_d     = '0;
            state_d = S_MAC;
         end
         S_MAC: begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (i_q == n_in_q - DIM_W'(1)) begin
               cnt_d   = CNT_W'(MAC_LAT - 1);
               state_d = S_DRAIN;
            end else begin
               i_d = i_q + DIM_W'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == '0) state_d = S_ACT;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_ACT: state_d = S_WRITE;
         S_WRITE: begin
            if (j_q == n_out_q - DIM_W'(1)) begin
               state_d = S_DONE;
            end else begin
               j_d     = j_q + DIM_W'(1);
               state_d = S_CLEAR;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort_req && busy_q) state_d = S_IDLE;

      // Outputs are registered from the next state so they align with it.
      busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
      mac_clr_d    = (state_d == S_CLEAR);
      mac_en_d     = (state_d == S_MAC);
      act_strobe_d = (state_d == S_ACT);
      y_we_d       = (state_d == S_WRITE);
      if (state_d == S_MAC) begin
         w_addr_d = ptr_d;
         x_addr_d = i_d;
      end
      if (state_d == S_WRITE) y_addr_d = j_d;
      irq_d  = done_d & irq_en_d;
      leds_d = {done_d, busy_d, j_d[5:0]};

      if (avs_read) begin
         unique case (avs_address)
            2'd0: avs_readdata_d = {30'd0, irq_en_q, 1'b0};
            2'd1: avs_readdata_d = (32'(j_q) << 8) | {30'd0, done_q, busy_q};
            2'd2: avs_readdata_d = (32'(n_out_q) << 8) | 32'(n_in_q);
            2'd3: avs_readdata_d = 32'(base_q);
            default: avs_readdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q        <= S_IDLE;
         irq_en_q       <= 1'b0;
         done_q         <= 1'b0;
         n_in_q         <= '0;
         n_out_q        <= '0;
         base_q         <= '0;
         ptr_q          <= '0;
         i_q            <= '0;
         j_q            <= '0;
         cnt_q          <= '0;
         avs_readdata_q <= 32'd0;
         w_addr_q       <= '0;
         x_addr_q       <= '0;
         y_addr_q       <= '0;
         mac_clr_q      <= 1'b0;
         mac_en_q       <= 1'b0;
         act_strobe_q   <= 1'b0;
         y_we_q         <= 1'b0;
         irq_q          <= 1'b0;
         leds_q         <= 8'd0;
      end else begin
         state_q        <= state_d;
         irq_en_q       <= irq_en_d;
         done_q         <= done_d;
         n_in_q         <= n_in_d;
         n_out_q        <= n_out_d;
         base_q         <= base_d;
         ptr_q          <= ptr_d;
         i_q            <= i_d;
         j_q            <= j_d;
         cnt_q          <= cnt_d;
         avs_readdata_q <= avs_readdata_d;
         w_addr_q       <= w_addr_d;
         x_addr_q       <= x_addr_d;
         y_addr_q       <= y_addr_d;
         mac_clr_q      <= mac_clr_d;
         mac_en_q       <= mac_en_d;
         act_strobe_q   <= act_strobe_d;
         y_we_q         <= y_we_d;
         irq_q          <= irq_d;
         leds_q         <= leds_d;
      end
   end

   assign avs_readdata = avs_readdata_q;
   assign w_addr       = w_addr_q;
   assign x_addr       = x_addr_q;
   assign y_addr       = y_addr_q;
   assign mac_clr      = mac_clr_q;
   assign mac_en       = mac_en_q;
   assign act_strobe   = act_strobe_q;
   assign y_we         = y_we_q;
   assign irq          = irq_q;
   assign leds         = leds_q;

endmodule

// File: tb/tb_ann_mac_sequencer.sv
// Directed self-checking bench for ann_mac_sequencer (ADDR_W=16, DIM_W=8, MAC_LAT=2).
module tb_ann_mac_sequencer;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned DIM_W   = 8;
   localparam int unsigned MAC_LAT = 2;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n = 1'b0;
   logic [1:0]        avs_address = 2'd0;
   logic              avs_read = 1'b0;
   logic              avs_write = 1'b0;
   logic [31:0]       avs_writedata = 32'd0;
   logic [31:0]       avs_readdata;
   logic [ADDR_W-1:0] w_addr;
   logic [DIM_W-1:0]  x_addr;
   logic              mac_clr, mac_en, act_strobe, y_we, irq;
   logic [DIM_W-1:0]  y_addr;
   logic [7:0]        leds;

   int n_chk = 0;
   int n_pass = 0;

   logic [31:0] wq[$];
   logic [31:0] xq[$];
   logic [31:0] yq[$];
   int clr_cnt = 0, act_cnt = 0, busy_cnt = 0, excl_err = 0;

   ann_mac_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .MAC_LAT(MAC_LAT)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .w_addr(w_addr), .x_addr(x_addr), .mac_clr(mac_clr), .mac_en(mac_en),
      .act_strobe(act_strobe), .y_addr(y_addr), .y_we(y_we), .irq(irq), .leds(leds)
   );

   always #5 clk_clk = ~clk_clk;

   // Datapath strobe monitor, sampled on the falling edge.
   always @(negedge clk_clk) begin
      if (mac_en) begin
         wq.push_back(32'(w_addr));
         xq.push_back(32'(x_addr));
      end
      if (y_we) yq.push_back(32'(y_addr));
      if (mac_clr) clr_cnt++;
      if (act_strobe) act_cnt++;
      if (leds[6]) busy_cnt++;
      if ((32'(mac_en) + 32'(mac_clr) + 32'(act_strobe) + 32'(y_we)) > 32'd1) excl_err++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic check_q(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
      check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
      for (int k = 0; k < exp.size(); k++)
         check($sformatf("%s[%0d]", tag, k), (k < got.size()) ? got[k] : 32'hDEAD_BEEF, exp[k]);
   endtask

   task automatic clear_mon();
      wq.delete(); xq.delete(); yq.delete();
      clr_cnt = 0; act_cnt = 0; busy_cnt = 0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk_clk);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(negedge clk_clk);
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk_clk);
      avs_address = a; avs_read = 1'b1;
      @(negedge clk_clk);
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n;
      n = 0;
      while (!leds[7] && n < budget) begin
         @(negedge clk_clk);
         n++;
      end
      if (!leds[7]) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] e[$];
      int n;

      // Reset state
      #12;
      check("rst_strobes", {28'd0, mac_clr, mac_en, act_strobe, y_we}, 32'd0);
      check("rst_leds", 32'(leds), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", avs_readdata, 32'd0);
      check("rst_addr", {w_addr, x_addr, y_addr}, 32'd0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      rd(2'd1, d); check("rst_status", d, 32'h0);
      rd(2'd2, d); check("rst_dims", d, 32'h0);

      // Basic run: n_in=3, n_out=2, BASE=0x100
      wr(2'd2, 32'h0000_0203);
      wr(2'd3, 32'h0000_0100);
      rd(2'd2, d); check("dims_rb", d, 32'h0203);
      rd(2'd3, d); check("base_rb", d, 32'h0100);
      clear_mon();
      wr(2'd0, 32'h1);
      check("basic_clr_first", 32'(mac_clr), 32'd1);
      @(negedge clk_clk);
      check("basic_mac_first", {15'd0, mac_en, w_addr}, {15'd0, 1'b1, 16'h0100});
      wait_done(100, "basic");
      check("basic_irq_off", 32'(irq), 32'd0);
      check("basic_leds_done", 32'(leds), 32'h81);
      @(negedge clk_clk);
      e = {32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105}; check_q("basic_w", wq, e);
      e = {32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};             check_q("basic_x", xq, e);
      e = {32'd0, 32'd1};                                         check_q("basic_y", yq, e);
      check("basic_busy", 32'(busy_cnt), 32'd16);
      check("basic_clr_cnt", 32'(clr_cnt), 32'd2);
      check("basic_act_cnt", 32'(act_cnt), 32'd2);
      check("basic_hold", {w_addr, x_addr, y_addr}, {16'h0105, 8'd2, 8'd1});
      rd(2'd1, d); check("basic_status", d, 32'h0102);

      // Interrupt
      wr(2'd0, 32'h2);
      rd(2'd0, d); check("irq_en_rb", d, 32'h2);
      clear_mon();
      wr(2'd0, 32'h3);
      wait_done(100, "irq");
      check("irq_with_done", 32'(irq), 32'd1);
      wr(2'd1, 32'h2);
      check("irq_w1c", {30'd0, irq, leds[7]}, 32'd0);
      rd(2'd1, d); check("irq_status", d, 32'h0100);
      wr(2'd0, 32'h0);

      // Zero dimension
      wr(2'd2, 32'h0000_0200);
      clear_mon();
      wr(2'd0, 32'h1);
      check("zero_done", {30'd0, leds[7], leds[6]}, 32'h2);
      repeat (10) @(negedge clk_clk);
      check("zero_mac", 32'(wq.size()), 32'd0);
      check("zero_ywe", 32'(yq.size()), 32'd0);
      check("zero_clr", 32'(clr_cnt), 32'd0);

      // Abort during MAC of neuron 1
      wr(2'd2, 32'h0000_0403);
      wr(2'd3, 32'h0000_0200);
      clear_mon();
      wr(2'd0, 32'h1);
      n = 0;
      while (!(mac_en && yq.size() == 1) && n < 100) begin
         @(negedge clk_clk);
         n++;
      end
      check("abort_reach_j1", 32'(mac_en && yq.size() == 1), 32'd1);
      wr(2'd0, 32'h4);
      check("abort_idle", {30'd0, mac_en, leds[6]}, 32'd0);
      repeat (20) @(negedge clk_clk);
      check("abort_no_ywe", 32'(yq.size()), 32'd1);
      rd(2'd1, d); check("abort_status", d, 32'h0100);
      clear_mon();
      wr(2'd0, 32'h1);
      wait_done(200, "restart");
      @(negedge clk_clk);
      check("restart_w0", (wq.size() > 0) ? wq[0] : 32'hDEAD_BEEF, 32'h200);
      check("restart_wlast", (wq.size() == 12) ? wq[11] : 32'hDEAD_BEEF, 32'h20B);
      e = {32'd0, 32'd1, 32'd2, 32'd3}; check_q("restart_y", yq, e);
      check("restart_busy", 32'(busy_cnt), 32'd32);

      // Busy protection and address wrap
      wr(2'd2, 32'h0000_0104);
      wr(2'd3, 32'h0000_FFFE);
      clear_mon();
      wr(2'd0, 32'h1);
      wr(2'd2, 32'h0000_0505);
      wr(2'd0, 32'h1);
      wait_done(100, "wrap");
      repeat (10) @(negedge clk_clk);
      e = {32'hFFFE, 32'hFFFF, 32'h0000, 32'h0001}; check_q("wrap_w", wq, e);
      e = {32'd0, 32'd1, 32'd2, 32'd3};             check_q("wrap_x", xq, e);
      e = {32'd0};                                  check_q("wrap_y", yq, e);
      check("wrap_busy", 32'(busy_cnt), 32'd9);
      rd(2'd2, d); check("wrap_dims_kept", d, 32'h0104);
      check("excl", 32'(excl_err), 32'd0);

      // Reset asserted mid-MAC
      wr(2'd2, 32'h0000_0203);
      wr(2'd3, 32'h0000_0100);
      wr(2'd0, 32'h3);
      n = 0;
      while (!mac_en && n < 20) begin
         @(negedge clk_clk);
         n++;
      end
      check("rst2_in_mac", 32'(mac_en), 32'd1);
      #2 reset_reset_n = 1'b0;
      #1;
      check("rst2_strobes", {28'd0, mac_clr, mac_en, act_strobe, y_we}, 32'd0);
      check("rst2_leds_irq", {23'd0, irq, leds}, 32'd0);
      check("rst2_addr", {w_addr, x_addr, y_addr}, 32'd0);
      repeat (2) @(negedge clk_clk);
      check("rst2_hold", {27'd0, mac_clr, mac_en, act_strobe, y_we, leds[6]}, 32'd0);
      reset_reset_n = 1'b1;
      rd(2'd0, d); check("rst2_ctrl", d, 32'h0);
      rd(2'd1, d); check("rst2_status", d, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
